mac_arbiter: RTL and testbench

Round-robin scheduler that shares one byte-serial 8x8 multiply-accumulate engine among NREQ requesters. Each requester presents one attribute word and one coefficient word. The block grants one requester at a time and steps the engine through the byte lanes, most significant first. It returns the 20-bit sum of the per-byte products with the winner's ID. It sits between the attribute/coefficient fetch ports and the result collector of the BDD accelerator datapath.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_lane_engine.sv | 48 ++++
 rtl/mac_arbiter.sv | 125 ++++++++++++
 tb/tb_mac_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the byte-serial MAC arbiter and its lane engine.
// Holds the FSM encoding, lane width and the default parameter widths.
package mac_pkg;

    localparam int LANE_W             = 8;
    localparam int DEF_NREQ           = 4;
    localparam int DEF_ATTR_WIDTH     = 24;
    localparam int DEF_RAM1_DATA_WIDTH = 24;
    localparam int DEF_ACC_WIDTH      = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nlane(input int width);
        return width / LANE_W;
    endfunction

endpackage

// File: rtl/mac_lane_engine.sv
// Byte-serial 8x8 multiply-accumulate: one lane product added per enabled cycle.
// Accumulator updates on the edge after en; clr has priority over en; no backpressure.
module mac_lane_engine
    import mac_pkg::*;
#(
    parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int LANE_IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [LANE_IDX_W-1:0] lane,
    input  logic [ATTR_WIDTH-1:0] attr,
    input  logic [ATTR_WIDTH-1:0] coeff,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_W = 2 * LANE_W;
    localparam int SUM_W  = (ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W;

    logic [LANE_W-1:0]    w_attr_byte;
    logic [LANE_W-1:0]    w_coeff_byte;
    logic [PROD_W-1:0]    w_prod;
    logic [SUM_W-1:0]     w_sum;
    logic [ACC_WIDTH-1:0] r_acc;

    assign w_attr_byte  = attr[lane*LANE_W +: LANE_W];
    assign w_coeff_byte = coeff[lane*LANE_W +: LANE_W];
    assign w_prod       = PROD_W'(w_attr_byte) * PROD_W'(w_coeff_byte);

    // Sum is formed wide enough for one product; upper bits drop only for narrow ACC_WIDTH.
    assign w_sum = SUM_W'(r_acc) + SUM_W'(w_prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin share of one byte-serial MAC among NREQ requesters; result NLANE+1 cycles after grant.
// Holds DONE until rsp_ready, and no requester is granted while a result is pending.
module mac_arbiter
    import mac_pkg::*;
#(
    parameter int NREQ            = DEF_NREQ,
    parameter int ATTR_WIDTH      = DEF_ATTR_WIDTH,
    parameter int RAM1_DATA_WIDTH = DEF_RAM1_DATA_WIDTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ*ATTR_WIDTH-1:0]        req_attr,
    input  logic [NREQ*RAM1_DATA_WIDTH-1:0]   req_coeff,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [ACC_WIDTH-1:0]              rsp_data,
    output logic [$clog2(NREQ)-1:0]           rsp_id,
    output logic                              busy
);

    localparam int NLANE = nlane(ATTR_WIDTH);
    localparam int LIW   = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int IDW   = $clog2(NREQ);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDW-1:0]             r_rr_ptr;
    logic [IDW-1:0]             r_rsp_id;
    logic [LIW-1:0]             r_lane;
    logic [ATTR_WIDTH-1:0]      r_attr;
    logic [RAM1_DATA_WIDTH-1:0] r_coeff;
    logic                       w_any;
    logic [IDW-1:0]             w_gnt_idx;
    logic                       w_grant;
    logic [IDW-1:0]             w_rr_nxt;
    logic [ACC_WIDTH-1:0]       w_acc;

    // First valid requester at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        int             v_idx;
        logic [IDW-1:0] v_sel;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        v_idx     = 0;
        v_sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) begin
                v_idx = v_idx - NREQ;
            end
            v_sel = IDW'(v_idx);
            if (!w_any && req_valid[v_sel]) begin
                w_any     = 1'b1;
                w_gnt_idx = v_sel;
            end
        end
    end

    assign w_grant  = (r_state == IDLE) && rst_n && w_any;
    assign w_rr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = MAC;
            MAC:     if (r_lane == '0) w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_rsp_id <= '0;
            r_lane   <= '0;
            r_attr   <= '0;
            r_coeff  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_attr   <= req_attr[w_gnt_idx*ATTR_WIDTH +: ATTR_WIDTH];
                r_coeff  <= req_coeff[w_gnt_idx*RAM1_DATA_WIDTH +: RAM1_DATA_WIDTH];
                r_rsp_id <= w_gnt_idx;
                r_rr_ptr <= w_rr_nxt;
                r_lane   <= LIW'(NLANE - 1);
            end else if (r_state == MAC) begin
                r_lane <= r_lane - LIW'(1);
            end
        end
    end

    mac_lane_engine #(
        .ATTR_WIDTH (ATTR_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .LANE_IDX_W (LIW)
    ) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_grant),
        .en    (r_state == MAC),
        .lane  (r_lane),
        .attr  (r_attr),
        .coeff (r_coeff),
        .acc   (w_acc)
    );

    // The accumulator is frozen outside MAC, so it doubles as the response register.
    assign rsp_data  = w_acc;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: latency, arithmetic, round-robin order, stall and reset abort.
module tb_mac_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 24;
    localparam int ACCW = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_attr;
    logic [NREQ*AW-1:0]   req_coeff;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ACCW-1:0]      rsp_data;
    logic [1:0]           rsp_id;
    logic                 busy;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_arbiter #(
        .NREQ            (NREQ),
        .ATTR_WIDTH      (AW),
        .RAM1_DATA_WIDTH (AW),
        .ACC_WIDTH       (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_attr  (req_attr),
        .req_coeff (req_coeff),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_req(input int idx, input logic [23:0] a, input logic [23:0] c,
                          input logic [31:0] exp_data, input string tag);
        bit ok;
        int t0;
        req_attr[idx*AW +: AW]  = a;
        req_coeff[idx*AW +: AW] = c;
        req_valid[idx]          = 1'b1;
        #1;
        wait_grant(ok);
        check({tag, " grant"}, 32'(req_ready), 32'(1 << idx));
        t0 = cyc;
        tick();
        req_valid[idx] = 1'b0;
        #1;
        wait_rsp(ok);
        check({tag, " latency"}, 32'(cyc - t0), 32'd4);
        check({tag, " data"}, 32'(rsp_data), exp_data);
        check({tag, " id"}, 32'(rsp_id), 32'(idx));
        tick();
    endtask

    initial begin
        bit ok;
        int bad;
        int nrdy;
        int t0;
        int tprev;
        int e;

        rst_n     = 1'b0;
        req_valid = '0;
        req_attr  = '0;
        req_coeff = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset rsp_id", 32'(rsp_id), 32'd0);
        rst_n = 1'b1;
        tick();

        do_req(0, 24'h010203, 24'h040506, 32'd32, "single");
        do_req(2, 24'hFFFFFF, 24'hFFFFFF, 32'd195075, "max");

        // rr_ptr is now 3; stay quiet, then requesters 1 and 3 compete.
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy || rsp_valid || req_ready != '0) bad++;
        end
        check("idle quiet", 32'(bad), 32'd0);

        req_attr[1*AW +: AW]  = 24'h000102;
        req_coeff[1*AW +: AW] = 24'h000304;
        req_attr[3*AW +: AW]  = 24'h070000;
        req_coeff[3*AW +: AW] = 24'h090000;
        req_valid = 4'b1010;
        #1;
        wait_grant(ok);
        check("ptr hold grant", 32'(req_ready), 32'd8);
        tick();
        req_valid[3] = 1'b0;
        #1;
        wait_rsp(ok);
        check("ptr hold data", 32'(rsp_data), 32'd63);
        check("ptr hold id", 32'(rsp_id), 32'd3);
        tick();
        check("wrap regrant", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        #1;
        wait_rsp(ok);
        check("wrap data", 32'(rsp_data), 32'd11);
        check("wrap id", 32'(rsp_id), 32'd1);
        tick();

        // Backpressure: rr_ptr is 2, requester 0 alone wins, requester 2 waits behind the stall.
        rsp_ready             = 1'b0;
        req_attr[0*AW +: AW]  = 24'h000010;
        req_coeff[0*AW +: AW] = 24'h000010;
        req_valid[0]          = 1'b1;
        #1;
        wait_grant(ok);
        check("bp grant", 32'(req_ready), 32'd1);
        tick();
        req_valid[0]          = 1'b0;
        req_attr[2*AW +: AW]  = 24'h020000;
        req_coeff[2*AW +: AW] = 24'h030000;
        req_valid[2]          = 1'b1;
        #1;
        wait_rsp(ok);
        check("bp data", 32'(rsp_data), 32'd256);
        check("bp id", 32'(rsp_id), 32'd0);
        bad  = 0;
        nrdy = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!rsp_valid || rsp_data != 20'd256 || rsp_id != 2'd0 || !busy) bad++;
            if (req_ready != '0) nrdy++;
        end
        check("bp stable", 32'(bad), 32'd0);
        check("bp no ready", 32'(nrdy), 32'd0);
        rsp_ready = 1'b1;
        #1;
        tick();
        check("bp regrant", 32'(req_ready), 32'd4);
        tick();
        req_valid[2] = 1'b0;
        #1;
        wait_rsp(ok);
        check("bp2 data", 32'(rsp_data), 32'd6);
        check("bp2 id", 32'(rsp_id), 32'd2);
        tick();

        // Reset one cycle into MAC: rr_ptr is 3, requester 1 wins, then the result is aborted.
        req_attr[1*AW +: AW]  = 24'h050000;
        req_coeff[1*AW +: AW] = 24'h050000;
        req_valid[1]          = 1'b1;
        #1;
        wait_grant(ok);
        check("abort grant", 32'(req_ready), 32'd2);
        tick();
        req_valid[1] = 1'b0;
        #1;
        check("abort busy pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort req_ready", 32'(req_ready), 32'd0);
        check("abort rsp_data", 32'(rsp_data), 32'd0);
        check("abort rsp_id", 32'(rsp_id), 32'd0);
        rst_n = 1'b1;
        bad   = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (rsp_valid || busy) bad++;
        end
        check("abort no rsp", 32'(bad), 32'd0);

        // Fairness from rr_ptr 0: every requester stays valid; requester i sums to 3*(i+1).
        for (int i = 0; i < NREQ; i++) begin
            req_attr[i*AW +: AW]  = 24'(24'h010101 * (i + 1));
            req_coeff[i*AW +: AW] = 24'h010101;
        end
        req_valid = 4'hF;
        #1;
        tprev = 0;
        for (int g = 0; g < 5; g++) begin
            e = g % NREQ;
            wait_grant(ok);
            check($sformatf("fair%0d grant", g), 32'(req_ready), 32'(1 << e));
            t0 = cyc;
            if (g > 0) check($sformatf("fair%0d spacing", g), 32'(t0 - tprev), 32'd5);
            tprev = t0;
            for (int k = 0; k < 4; k++) tick();
            check($sformatf("fair%0d valid", g), 32'(rsp_valid), 32'd1);
            check($sformatf("fair%0d data", g), 32'(rsp_data), 32'(3 * (e + 1)));
            check($sformatf("fair%0d id", g), 32'(rsp_id), 32'(e));
            tick();
        end
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
